// File: rtl/cpu_pkg.sv
// cpu_pkg: shared register-file widths and the writeback request type.
package cpu_pkg;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int REG_ADDR_W = $clog2(NREG);

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        reg_addr_t       rd;
        logic [XLEN-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: writeback sources, scoreboard and register-file write port.
interface wb_arbiter_if;
    import cpu_pkg::*;
    logic            pipe_valid;
    reg_addr_t       pipe_rd;
    logic [XLEN-1:0] pipe_data;
    logic            ll_valid;
    logic            ll_ready;
    reg_addr_t       ll_rd;
    logic [XLEN-1:0] ll_data;
    logic            issue_valid;
    reg_addr_t       issue_rd;
    logic            stall_pipe;
    logic [NREG-1:0] busy;
    logic            rf_we;
    reg_addr_t       rf_rd_addr;
    logic [XLEN-1:0] rf_wdata;
    logic            proto_err;

    modport master (
        output pipe_valid, pipe_rd, pipe_data, ll_valid, ll_rd, ll_data, issue_valid, issue_rd,
        input  ll_ready, stall_pipe, busy, rf_we, rf_rd_addr, rf_wdata, proto_err
    );
    modport slave (
        input  pipe_valid, pipe_rd, pipe_data, ll_valid, ll_rd, ll_data, issue_valid, issue_rd,
        output ll_ready, stall_pipe, busy, rf_we, rf_rd_addr, rf_wdata, proto_err
    );
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of writeback requests; head is visible combinationally.
module wb_fifo import cpu_pkg::*; #(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  wb_req_t       din,
    output wb_req_t       dout,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);
    wb_req_t        mem [DEPTH];
    logic [AW-1:0]  wptr, rptr;

    assign dout  = mem[rptr];
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= din;
    end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges pipeline and long-latency writebacks onto the register-file
// write port, with starvation backpressure and a pending-destination scoreboard.
module wb_arbiter import cpu_pkg::*; #(
    parameter int LL_DEPTH     = 2,
    parameter int STARVE_LIMIT = 4
) (
    input logic         clk,
    input logic         rst_n,
    wb_arbiter_if.slave bus
);
    localparam int CW = $clog2(LL_DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    wb_req_t         ll_req, head;
    logic [CW-1:0]   count;
    logic            full, empty, pipe_win, pop, push, wr;
    logic [SW-1:0]   starve, starve_nxt;
    logic [NREG-1:0] busy_nxt;

    assign ll_req      = '{rd: bus.ll_rd, data: bus.ll_data};
    assign pipe_win    = bus.pipe_valid && bus.pipe_rd != '0;
    assign pop         = !pipe_win && !empty;
    assign wr          = pipe_win || pop;
    assign bus.ll_ready = count < CW'(LL_DEPTH);
    // x0 results complete the handshake but are dropped rather than queued
    assign push        = bus.ll_valid && !full && bus.ll_rd != '0;
    assign starve_nxt  = (empty || pop) ? '0 :
                         (starve == SW'(STARVE_LIMIT)) ? starve : starve + 1'b1;

    always_comb begin
        busy_nxt = bus.busy;
        if (pop) busy_nxt[head.rd] = 1'b0;
        if (bus.issue_valid && bus.issue_rd != '0) busy_nxt[bus.issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    wb_fifo #(.DEPTH(LL_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (ll_req),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rf_we      <= 1'b0;
            bus.rf_rd_addr <= '0;
            bus.rf_wdata   <= '0;
            bus.busy       <= '0;
            bus.stall_pipe <= 1'b0;
            bus.proto_err  <= 1'b0;
            starve         <= '0;
        end else begin
            bus.rf_we <= wr;
            if (wr) begin
                bus.rf_rd_addr <= pipe_win ? bus.pipe_rd : head.rd;
                bus.rf_wdata   <= pipe_win ? bus.pipe_data : head.data;
            end
            bus.busy       <= busy_nxt;
            starve         <= starve_nxt;
            bus.stall_pipe <= starve_nxt == SW'(STARVE_LIMIT);
            bus.proto_err  <= bus.proto_err || (bus.pipe_valid && bus.stall_pipe);
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed checks of arbitration, FIFO order, starvation, scoreboard and reset.
module tb_wb_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    wb_arbiter_if bus ();

    wb_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input logic [4:0] rd, input logic [31:0] data);
        chk({tag, "_we"}, bus.rf_we, 1);
        chk({tag, "_rd"}, bus.rf_rd_addr, rd);
        chk({tag, "_data"}, bus.rf_wdata, data);
    endtask

    task automatic idle();
        bus.pipe_valid = 0; bus.pipe_rd = 0; bus.pipe_data = 0;
        bus.ll_valid = 0; bus.ll_rd = 0; bus.ll_data = 0;
        bus.issue_valid = 0; bus.issue_rd = 0;
    endtask

    task automatic pipe(input logic [4:0] rd, input logic [31:0] data);
        bus.pipe_valid = 1; bus.pipe_rd = rd; bus.pipe_data = data;
    endtask

    task automatic ll(input logic [4:0] rd, input logic [31:0] data);
        bus.ll_valid = 1; bus.ll_rd = rd; bus.ll_data = data;
    endtask

    initial begin
        idle();
        tick(); tick();
        chk("rst_we", bus.rf_we, 0);
        chk("rst_addr", bus.rf_rd_addr, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_stall", bus.stall_pipe, 0);
        chk("rst_proto", bus.proto_err, 0);
        chk("rst_ready", bus.ll_ready, 1);
        rst_n = 1;

        pipe(5, 32'h1234);
        tick(); idle();
        chk_wr("pipe1", 5, 32'h1234);
        tick();
        chk("pipe1_after", bus.rf_we, 0);

        bus.issue_valid = 1; bus.issue_rd = 7;
        tick(); idle();
        chk("issue7", bus.busy, 64'h80);
        tick();
        chk("issue7_hold", bus.busy, 64'h80);
        ll(7, 32'hDEAD);
        tick(); idle();
        chk("ll7_push_we", bus.rf_we, 0);
        chk("ll7_push_busy", bus.busy, 64'h80);
        tick();
        chk_wr("ll7", 7, 32'hDEAD);
        chk("ll7_busy_clr", bus.busy, 0);

        pipe(9, 32'h90); ll(3, 32'h11);
        tick();
        pipe(9, 32'h91); ll(4, 32'h22);
        tick(); bus.ll_valid = 0;
        chk_wr("starve_b", 9, 32'h91);
        chk("full_ready", bus.ll_ready, 0);
        chk("stall_early", bus.stall_pipe, 0);
        tick(); tick();
        chk("stall_c3", bus.stall_pipe, 0);
        tick();
        chk("stall_c4", bus.stall_pipe, 1);
        chk("proto_pre", bus.proto_err, 0);
        pipe(9, 32'h95);
        tick(); idle();
        chk_wr("stalled_pipe", 9, 32'h95);
        chk("proto_set", bus.proto_err, 1);
        chk("stall_sat", bus.stall_pipe, 1);
        tick();
        chk_wr("drain_x3", 3, 32'h11);
        chk("stall_clr", bus.stall_pipe, 0);
        chk("ready_back", bus.ll_ready, 1);
        tick();
        chk_wr("drain_x4", 4, 32'h22);
        tick();
        chk("drain_done", bus.rf_we, 0);

        ll(2, 32'h2B);
        tick(); idle();
        pipe(1, 32'hA1);
        tick(); idle();
        chk_wr("same_x1", 1, 32'hA1);
        tick();
        chk_wr("same_x2", 2, 32'h2B);

        pipe(0, 32'hFF);
        tick(); idle();
        chk("pipe_x0", bus.rf_we, 0);
        ll(0, 32'hEE);
        chk("ll_x0_ready", bus.ll_ready, 1);
        tick(); idle();
        chk("ll_x0_ready_after", bus.ll_ready, 1);
        chk("ll_x0_we", bus.rf_we, 0);
        tick();
        chk("ll_x0_nowrite", bus.rf_we, 0);
        bus.issue_valid = 1; bus.issue_rd = 0;
        tick(); idle();
        chk("issue_x0", bus.busy, 0);

        bus.issue_valid = 1; bus.issue_rd = 3;
        tick();
        bus.issue_rd = 4;
        tick(); idle();
        pipe(9, 32'h99); ll(3, 32'h33);
        tick();
        ll(4, 32'h44);
        tick();
        chk("pre_rst_busy", bus.busy, 64'h18);
        chk("pre_rst_ready", bus.ll_ready, 0);
        chk("pre_rst_we", bus.rf_we, 1);
        chk("pre_rst_proto", bus.proto_err, 1);
        rst_n = 0;
        #2;
        chk("mid_rst_we", bus.rf_we, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_ready", bus.ll_ready, 1);
        chk("mid_rst_stall", bus.stall_pipe, 0);
        chk("mid_rst_proto", bus.proto_err, 0);
        idle();
        tick();
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_we", bus.rf_we, 0);
        end
        chk("post_rst_busy", bus.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
